arb_mux_4: RTL and testbench

Four-requester round-robin arbiter that shares one `mux_4` datapath among independent valid/ready streams and registers the selected beat into a single output stage. It sits in front of any shared consumer (bus, FIFO, serializer) that several producers must feed. It computes the mux select from request state and a rotating priority pointer. With packet locking compiled in, it holds the grant for a whole multi-beat packet.

---
 rtl/arb_pkg.sv | 17 +
 rtl/mux_4.sv | 27 ++
 rtl/arb_mux_4.sv | 161 ++++++++++++++++
 tb/tb_arb_mux_4.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the arb_mux_4 arbiter.
//   N_REQ       : number of requesters sharing the datapath
//   req_idx_t   : requester index / mux select
//   arb_state_t : packet-lock FSM state (IDLE, LOCKED). The FSM is only
//                 built when ARB_MUX_4_LOCK_EN is defined.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mux_4.sv
// mux_4: plain 4:1 data multiplexer, purely combinational.
//   i_sel        : select (0..3)
//   i_d0..i_d3   : data inputs, DATA_WIDTH bits each
//   o_y          : selected data
module mux_4 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [1:0]            i_sel,
  input  logic [DATA_WIDTH-1:0] i_d0,
  input  logic [DATA_WIDTH-1:0] i_d1,
  input  logic [DATA_WIDTH-1:0] i_d2,
  input  logic [DATA_WIDTH-1:0] i_d3,
  output logic [DATA_WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0: o_y = i_d0;
      2'd1: o_y = i_d1;
      2'd2: o_y = i_d2;
      2'd3: o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end

endmodule

// File: rtl/arb_mux_4.sv
// arb_mux_4: four-requester round-robin arbiter in front of a shared mux_4
// datapath, with a single registered output stage.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (4 bits each)
//   req_data_0..3         : per-requester beat data
//   req_last              : per-requester end-of-packet flag
//   out_data/out_last/out_src/out_valid : registered output beat
//   out_ready             : downstream accept
//   o_dbg_state           : packet-lock FSM state (constant IDLE when the
//                           lock feature is not built)
//
// Handshake: a beat moves when valid && ready in the same cycle. ready never
// depends on data; the output register loads when it is empty or draining
// (load = !out_valid || out_ready), and at most one req_ready bit is high.
//
// Build option ARB_MUX_4_LOCK_EN: when defined, the grant is held for a whole
// packet (first beat through the req_last beat) by a two-state FSM.
module arb_mux_4
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [DATA_WIDTH-1:0] req_data_0,
  input  logic [DATA_WIDTH-1:0] req_data_1,
  input  logic [DATA_WIDTH-1:0] req_data_2,
  input  logic [DATA_WIDTH-1:0] req_data_3,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output req_idx_t              out_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output arb_state_t            o_dbg_state
);

  // Search starts one past the last winner; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req,
                                         input req_idx_t ptr);
    logic     found;
    req_idx_t idx;
    req_idx_t cand;
    found = 1'b0;
    idx   = ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + req_idx_t'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  req_idx_t              r_last_grant;
  logic [N_REQ-1:0]      w_req_elig;
  logic [2:0]            w_pick;
  logic                  w_grant_valid;
  req_idx_t              w_gnt_idx;
  logic                  w_load;
  logic                  w_xfer;
  logic                  w_last_sel;
  logic                  w_end_arb;
  logic [DATA_WIDTH-1:0] w_mux_y;

`ifdef ARB_MUX_4_LOCK_EN
  arb_state_t r_state;
  arb_state_t w_state_nxt;
  req_idx_t   r_owner;
  req_idx_t   w_owner_nxt;

  // While locked only the owner is visible to the search, so the search
  // naturally returns the owner or nothing.
  assign w_req_elig  = (r_state == LOCKED) ? (req_valid & (N_REQ'(1) << r_owner))
                                           : req_valid;
  assign w_end_arb   = w_xfer && w_last_sel;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (w_xfer && !w_last_sel) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_gnt_idx;
        end
      end
      LOCKED: begin
        if (w_xfer && w_last_sel) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
`else
  assign w_req_elig  = req_valid;
  assign w_end_arb   = w_xfer;
  assign o_dbg_state = IDLE;
`endif

  assign w_pick        = rr_pick(w_req_elig, r_last_grant);
  assign w_grant_valid = w_pick[2];
  assign w_gnt_idx     = w_pick[1:0];
  assign w_load        = !out_valid || out_ready;
  assign w_xfer        = w_load && w_grant_valid;
  assign w_last_sel    = req_last[w_gnt_idx];

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt_idx] = 1'b1;
  end

  mux_4 #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .i_sel (w_gnt_idx),
    .i_d0  (req_data_0),
    .i_d1  (req_data_1),
    .i_d2  (req_data_2),
    .i_d3  (req_data_3),
    .o_y   (w_mux_y)
  );

  // Output stage: overwrite on transfer (also when draining the same cycle),
  // otherwise clear valid once the held beat is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (w_xfer) begin
      out_valid <= 1'b1;
      out_data  <= w_mux_y;
      out_last  <= w_last_sel;
      out_src   <= w_gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Reset value 3 gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst)            r_last_grant <= 2'd3;
    else if (w_end_arb) r_last_grant <= w_gnt_idx;
  end

endmodule

// File: tb/tb_arb_mux_4.sv
module tb_arb_mux_4;
  import arb_pkg::*;

  localparam int DW = 8;
`ifdef ARB_MUX_4_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic [3:0]    req_valid;
  logic [DW-1:0] d [4];
  logic [3:0]    req_last;
  logic [3:0]    req_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  req_idx_t      out_src;
  logic          out_valid;
  logic          out_ready;
  arb_state_t    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arb_mux_4 #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data_0  (d[0]),
    .req_data_1  (d[1]),
    .req_data_2  (d[2]),
    .req_data_3  (d[3]),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] last_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: pointer and owner as integers (-1 = no owner), output
  // stage as a holding slot.
  int            m_ptr = 3;
  int            m_owner = -1;
  logic          m_ov = 1'b0;
  logic          m_ol = 1'b0;
  logic [1:0]    m_os = 2'd0;
  logic [DW-1:0] m_od = '0;

  // ---------------- driver ----------------
  // Called just after a rising edge: drive, check ready, clock, check outputs.
  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l, input logic ordy);
    int   win;
    logic load;
    logic xfer;
    logic [3:0] exp_rdy;
    rst = r; req_valid = v; req_last = l; out_ready = ordy;
    #2;
    win = -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (win < 0 && v[idx] && (m_owner < 0 || m_owner == idx)) win = idx;
    end
    load = !m_ov || ordy;
    xfer = (win >= 0) && load;
    exp_rdy = xfer ? (4'b0001 << win) : 4'b0000;
    last_rdy = req_ready;
    if (!r) check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    #1;
    if (r) begin
      m_ptr = 3; m_owner = -1; m_ov = 0; m_ol = 0; m_os = 0; m_od = '0;
    end else if (xfer) begin
      m_ov = 1; m_od = d[win]; m_ol = l[win]; m_os = 2'(win);
      if (LOCK) begin
        if (l[win]) begin m_ptr = win; m_owner = -1; end
        else m_owner = win;
      end else begin
        m_ptr = win;
      end
    end else if (ordy) begin
      m_ov = 0;
    end
    check("out_regs", {20'd0, out_valid, out_last, out_src, out_data},
                      {20'd0, m_ov, m_ol, m_os, m_od});
`ifdef ARB_MUX_4_LOCK_EN
    check("lock_state", {31'd0, dbg_state == LOCKED}, {31'd0, m_owner >= 0});
`endif
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       r;
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic [1:0] exp_src;
    logic       exp_ov;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [1:0] exp_seq [4];
    rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    last_rdy = '0;
    @(posedge clk); #1;

    // Reset state.
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_out_src",   {30'd0, out_src},   32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_state",     {31'd0, dbg_state == LOCKED}, 32'd0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1);
    check("rst_req_ready", {28'd0, last_rdy}, 32'd0);

    // Rotation on all-valid and alternation on 1010.
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    tbl[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    tbl[10] = '{1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    for (int i = 0; i < 12; i++) begin
      rand_data();
      step(tbl[i].r, tbl[i].valid, tbl[i].last, tbl[i].ordy);
      if (!tbl[i].r) check($sformatf("tbl%0d_rdy", i), {28'd0, last_rdy}, {28'd0, tbl[i].exp_rdy});
      check($sformatf("tbl%0d_src", i), {30'd0, out_src}, {30'd0, tbl[i].exp_src});
      check($sformatf("tbl%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_ov});
    end

    // Backpressure: 0xA5 from requester 2 held for 3 stalled cycles.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    d[2] = 8'hA5;
    step(1'b0, 4'b0100, 4'b0100, 1'b1);
    check("bp_load_data", {24'd0, out_data}, 32'h0000_00A5);
    check("bp_load_src",  {30'd0, out_src}, 32'd2);
    d[2] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0100, 4'b0100, 1'b0);
      check("bp_hold_data", {24'd0, out_data}, 32'h0000_00A5);
      check("bp_hold_rdy",  {28'd0, last_rdy}, 32'd0);
      check("bp_hold_ov",   {31'd0, out_valid}, 32'd1);
    end
    step(1'b0, 4'b0000, 4'b0000, 1'b1);
    check("bp_drain_ov", {31'd0, out_valid}, 32'd0);

    // Packet from requester 0 with requester 1 valid throughout.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
`ifdef ARB_MUX_4_LOCK_EN
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd1};
    rand_data(); step(1'b0, 4'b0011, 4'b0010, 1'b1);
    check("pkt_src0", {30'd0, out_src}, {30'd0, exp_seq[0]});
    rand_data(); step(1'b0, 4'b0011, 4'b0010, 1'b1);
    check("pkt_src1", {30'd0, out_src}, {30'd0, exp_seq[1]});
    rand_data(); step(1'b0, 4'b0011, 4'b0011, 1'b1);
    check("pkt_src2", {30'd0, out_src}, {30'd0, exp_seq[2]});
`else
    exp_seq = '{2'd0, 2'd1, 2'd0, 2'd1};
    rand_data(); step(1'b0, 4'b0011, 4'b0010, 1'b1);
    check("pkt_src0", {30'd0, out_src}, {30'd0, exp_seq[0]});
    rand_data(); step(1'b0, 4'b0011, 4'b0010, 1'b1);
    check("pkt_src1", {30'd0, out_src}, {30'd0, exp_seq[1]});
    rand_data(); step(1'b0, 4'b0011, 4'b0010, 1'b1);
    check("pkt_src2", {30'd0, out_src}, {30'd0, exp_seq[2]});
`endif
    rand_data(); step(1'b0, 4'b0010, 4'b0010, 1'b1);
    check("pkt_src3", {30'd0, out_src}, {30'd0, exp_seq[3]});

`ifdef ARB_MUX_4_LOCK_EN
    // Owner drops valid mid-packet: nobody else is granted meanwhile.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    rand_data(); step(1'b0, 4'b0011, 4'b0010, 1'b1);
    check("drop_first_rdy", {28'd0, last_rdy}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      rand_data(); step(1'b0, 4'b0010, 4'b0010, 1'b1);
      check("drop_gap_rdy", {28'd0, last_rdy}, 32'd0);
      check("drop_gap_ov",  {31'd0, out_valid}, 32'd0);
      check("drop_gap_lock", {31'd0, dbg_state == LOCKED}, 32'd1);
    end
    rand_data(); step(1'b0, 4'b0011, 4'b0011, 1'b1);
    check("drop_resume_rdy", {28'd0, last_rdy}, 32'd1);
    check("drop_resume_src", {30'd0, out_src}, 32'd0);
    rand_data(); step(1'b0, 4'b0010, 4'b0010, 1'b1);
    check("drop_after_src", {30'd0, out_src}, 32'd1);
`endif

    // Reset while holding a beat (and locked in the lock build).
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    rand_data(); step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("mid_ov_before", {31'd0, out_valid}, 32'd1);
    step(1'b1, 4'b0100, 4'b0000, 1'b0);
    check("mid_rst_ov",    {31'd0, out_valid}, 32'd0);
    check("mid_rst_state", {31'd0, dbg_state == LOCKED}, 32'd0);
    rand_data(); step(1'b0, 4'b1111, 4'b1111, 1'b1);
    check("mid_rst_rdy", {28'd0, last_rdy}, 32'd1);
    check("mid_rst_src", {30'd0, out_src}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      logic [3:0] l;
      rand_data();
      v = 4'($urandom);
      for (int b = 0; b < 4; b++) l[b] = ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 59) == 0, v, l, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
